// File: rtl/countdown_ctrl.sv
// Arbitrates two requesters for a shared two-digit ASCII down-counter and paces its decrements.
// Optional abort input is enabled by defining COUNTDOWN_ABORT_EN.
module countdown_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [15:0] start0,
  input  logic [15:0] start1,
  input  logic [15:0] cnt_value,
`ifdef COUNTDOWN_ABORT_EN
  input  logic        abort,
`endif
  output logic        cnt_load,
  output logic [15:0] cnt_ascii,
  output logic        cnt_dec,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        fin,
  output logic        fin_id,
  output logic        err,
  output logic        err_id
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FINISH
  } state_e;

  localparam logic [15:0] ASCII_00   = 16'h3030;
  localparam logic [15:0] ASCII_UN   = 16'h554E;
  localparam logic [7:0]  PRESC_LAST = 8'(TICK_DIV - 1);

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic start_valid(input logic [15:0] v);
    return is_digit(v[15:8]) && is_digit(v[7:0]) && (v != ASCII_00);
  endfunction

  state_e      state_q;
  logic [7:0]  presc_q;
  logic        rr_q;
  logic        owner_q;
  logic        cnt_load_q;
  logic [15:0] cnt_ascii_q;
  logic [1:0]  grant_q;
  logic        busy_q;
  logic        fin_q;
  logic        fin_id_q;
  logic        err_q;
  logic        err_id_q;

  logic        winner;
  logic [15:0] start_sel;
  logic        start_ok;
  logic        tick;
  logic        at_un;
  logic        abort_now;

  // rr_q names the requester that wins the next tie.
  always_comb begin
    winner    = (req == 2'b11) ? rr_q : req[1];
    start_sel = winner ? start1 : start0;
    start_ok  = start_valid(start_sel);
    tick      = (presc_q == PRESC_LAST);
    at_un     = (cnt_value == ASCII_UN);
  end

`ifdef COUNTDOWN_ABORT_EN
  assign abort_now = abort && ((state_q == ST_LOAD) || (state_q == ST_RUN));
`else
  assign abort_now = 1'b0;
`endif

  // Decrement must be suppressed in the very cycle the counter shows "UN",
  // so this strobe is gated combinationally by the live counter value.
  assign cnt_dec = (state_q == ST_RUN) && tick && !at_un && !abort_now;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      cnt_load_q  <= 1'b0;
      cnt_ascii_q <= ASCII_00;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
      fin_id_q    <= 1'b0;
      err_q       <= 1'b0;
      err_id_q    <= 1'b0;
    end else begin
      cnt_load_q <= 1'b0;
      fin_q      <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|req) begin
            rr_q <= ~winner;
            if (start_ok) begin
              state_q     <= ST_LOAD;
              owner_q     <= winner;
              cnt_ascii_q <= start_sel;
              grant_q     <= winner ? 2'b10 : 2'b01;
              busy_q      <= 1'b1;
              cnt_load_q  <= 1'b1;
            end else begin
              err_q    <= 1'b1;
              err_id_q <= winner;
            end
          end
        end
        ST_LOAD: begin
          presc_q <= '0;
          if (abort_now) begin
            state_q  <= ST_FINISH;
            fin_q    <= 1'b1;
            fin_id_q <= owner_q;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (at_un || abort_now) begin
            state_q  <= ST_FINISH;
            presc_q  <= '0;
            fin_q    <= 1'b1;
            fin_id_q <= owner_q;
          end else begin
            presc_q <= tick ? 8'd0 : presc_q + 8'd1;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cnt_load  = cnt_load_q;
  assign cnt_ascii = cnt_ascii_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign fin       = fin_q;
  assign fin_id    = fin_id_q;
  assign err       = err_q;
  assign err_id    = err_id_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a behavioural two-digit ASCII down-counter attached.
module tb_countdown_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [15:0] start0 = 16'h3030;
  logic [15:0] start1 = 16'h3030;
  logic [15:0] cnt_value;
`ifdef COUNTDOWN_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        cnt_load;
  logic [15:0] cnt_ascii;
  logic        cnt_dec;
  logic [1:0]  grant;
  logic        busy;
  logic        fin;
  logic        fin_id;
  logic        err;
  logic        err_id;

  int n_checks = 0;
  int n_errors = 0;

  int n_load, n_dec, n_fin, n_err, n_excl, fin_cyc, cyc;
  int dec_cyc[$];
  int fin_ids[$];
  logic [15:0] hist[$];

  countdown_ctrl #(.TICK_DIV(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .start0    (start0),
    .start1    (start1),
    .cnt_value (cnt_value),
`ifdef COUNTDOWN_ABORT_EN
    .abort     (abort),
`endif
    .cnt_load  (cnt_load),
    .cnt_ascii (cnt_ascii),
    .cnt_dec   (cnt_dec),
    .grant     (grant),
    .busy      (busy),
    .fin       (fin),
    .fin_id    (fin_id),
    .err       (err),
    .err_id    (err_id)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] ascii_dec(input logic [15:0] v);
    if (v == 16'h3031) return 16'h554E;
    if (v[7:0] == 8'h30) return {v[15:8] - 8'd1, 8'h39};
    return {v[15:8], v[7:0] - 8'd1};
  endfunction

  // Attached down-counter
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) cnt_value <= 16'h3030;
    else if (cnt_load) cnt_value <= cnt_ascii;
    else if (cnt_dec) begin
      cnt_value <= ascii_dec(cnt_value);
      hist.push_back(ascii_dec(cnt_value));
    end
  end

  always @(negedge clock) begin
    if (cnt_load) n_load <= n_load + 1;
    if (cnt_dec) begin
      n_dec <= n_dec + 1;
      dec_cyc.push_back(cyc);
    end
    if (fin) begin
      n_fin <= n_fin + 1;
      fin_ids.push_back(int'(fin_id));
      fin_cyc <= cyc;
    end
    if (err) n_err <= n_err + 1;
    if ((int'(cnt_load) + int'(cnt_dec) + int'(fin) + int'(err)) > 1) n_excl <= n_excl + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_mon();
    n_load = 0; n_dec = 0; n_fin = 0; n_err = 0;
    dec_cyc.delete(); fin_ids.delete(); hist.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_load(input string tag, input int target, input int limit);
    int n = 0;
    while (n_load < target && n < limit) begin step(); n++; end
    check(tag, 32'(n_load >= target), 32'd1);
  endtask

  task automatic wait_fin(input string tag, input int target, input int limit);
    int n = 0;
    while (n_fin < target && n < limit) begin step(); n++; end
    check(tag, 32'(n_fin >= target), 32'd1);
  endtask

  task automatic wait_value(input string tag, input logic [15:0] v, input int limit);
    int n = 0;
    while (cnt_value != v && n < limit) begin step(); n++; end
    check(tag, 32'(cnt_value == v), 32'd1);
  endtask

  initial begin
    n_excl = 0; cyc = 0; fin_cyc = 0;
    clear_mon();

    // Reset state
    do_reset();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_load", 32'(cnt_load), 32'd0);
    check("rst_dec", 32'(cnt_dec), 32'd0);
    check("rst_fin", 32'(fin), 32'd0);
    check("rst_fin_id", 32'(fin_id), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_id", 32'(err_id), 32'd0);
    check("rst_ascii", 32'(cnt_ascii), 32'h3030);

    // Single requester, "03"
    clear_mon();
    start0 = 16'h3033;
    req = 2'b01;
    wait_load("t1_load_seen", 1, 10);
    check("t1_ascii", 32'(cnt_ascii), 32'h3033);
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 32'd1);
    req = 2'b00;
    wait_fin("t1_fin_seen", 1, 100);
    check("t1_dec_count", 32'(n_dec), 32'd3);
    check("t1_load_count", 32'(n_load), 32'd1);
    check("t1_value_un", 32'(cnt_value), 32'h554E);
    check("t1_fin_id", 32'(fin_id), 32'd0);
    if (dec_cyc.size() == 3) begin
      check("t1_gap01", 32'(dec_cyc[1] - dec_cyc[0]), 32'd4);
      check("t1_gap12", 32'(dec_cyc[2] - dec_cyc[1]), 32'd4);
      check("t1_fin_lat", 32'(fin_cyc - dec_cyc[2]), 32'd2);
    end
    step();
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_grant", 32'(grant), 32'd0);

    // Tie, both "02", round-robin from reset
    do_reset();
    clear_mon();
    start0 = 16'h3032;
    start1 = 16'h3032;
    req = 2'b11;
    wait_load("t2_load2_seen", 2, 60);
    check("t2_grant2", 32'(grant), 32'h2);
    req = 2'b00;
    wait_fin("t2_fin2_seen", 2, 60);
    if (fin_ids.size() == 2) begin
      check("t2_first_id", 32'(fin_ids[0]), 32'd0);
      check("t2_second_id", 32'(fin_ids[1]), 32'd1);
    end
    check("t2_dec_count", 32'(n_dec), 32'd4);
    step();
    step();

    // Invalid starts from requester 1
    clear_mon();
    start1 = 16'h3141;
    req = 2'b10;
    step();
    req = 2'b00;
    check("t3_err", 32'(err), 32'd1);
    check("t3_err_id", 32'(err_id), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    step();
    step();
    check("t3_err_count", 32'(n_err), 32'd1);
    check("t3_no_load", 32'(n_load), 32'd0);
    start1 = 16'h3030;
    req = 2'b10;
    step();
    req = 2'b00;
    check("t3_zero_err", 32'(err), 32'd1);
    check("t3_zero_err_id", 32'(err_id), 32'd1);
    check("t3_zero_busy", 32'(busy), 32'd0);
    step();
    check("t3_err_one_cycle", 32'(err), 32'd0);

    // "10" across the tens rollover
    clear_mon();
    start0 = 16'h3130;
    req = 2'b01;
    wait_load("t4_load_seen", 1, 10);
    req = 2'b00;
    wait_fin("t4_fin_seen", 1, 200);
    check("t4_dec_count", 32'(n_dec), 32'd10);
    if (hist.size() == 10) begin
      check("t4_first_val", 32'(hist[0]), 32'h3039);
      check("t4_last_val", 32'(hist[9]), 32'h554E);
    end
    check("t4_fin_id", 32'(fin_id), 32'd0);
    step();
    step();

    // Reset mid-RUN at "05"
    clear_mon();
    start0 = 16'h3037;
    req = 2'b01;
    wait_load("t5_load_seen", 1, 10);
    req = 2'b00;
    wait_value("t5_reach_05", 16'h3035, 100);
    reset = 1'b1;
    step();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_grant", 32'(grant), 32'd0);
    check("t5_dec", 32'(cnt_dec), 32'd0);
    check("t5_fin", 32'(fin), 32'd0);
    check("t5_ascii", 32'(cnt_ascii), 32'h3030);
    reset = 1'b0;
    repeat (10) step();
    check("t5_no_fin", 32'(n_fin), 32'd0);

`ifdef COUNTDOWN_ABORT_EN
    // Abort during RUN at "07"
    begin
      int base;
      clear_mon();
      start0 = 16'h3039;
      req = 2'b01;
      wait_load("t6_load_seen", 1, 10);
      req = 2'b00;
      wait_value("t6_reach_07", 16'h3037, 100);
      base = n_dec;
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t6_fin", 32'(fin), 32'd1);
      check("t6_fin_id", 32'(fin_id), 32'd0);
      step();
      check("t6_busy", 32'(busy), 32'd0);
      repeat (6) step();
      check("t6_no_dec", 32'(n_dec - base), 32'd0);
    end
`endif

    check("strobe_exclusive", 32'(n_excl), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
